// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the time-shared debounce controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

    localparam int N_CH_DEFAULT  = 8;
    localparam int CNT_W_DEFAULT = 4;

    // Index width that stays at least 1 bit for degenerate channel counts.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin successor; wraps explicitly so N_CH need not be a power of two.
    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/debounce_evt_slot.sv
// Single-entry valid/ready holding register for committed-level events.
// Latency: load visible on outputs one cycle after load_i.
// Backpressure: stall_o flags a pending event the consumer is not taking this cycle.
module debounce_evt_slot #(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [IDX_W-1:0] ch_i,
    input  logic             level_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] ch_o,
    output logic             level_o,
    output logic             stall_o
);

    logic             valid_q, valid_d;
    logic [IDX_W-1:0] ch_q, ch_d;
    logic             level_q, level_d;

    // Holding register; reset drops any pending event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ch_q    <= '0;
            level_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ch_q    <= ch_d;
            level_q <= level_d;
        end
    end

    // A load wins over an accept so back-to-back events need no bubble;
    // the producer only loads when not stalled, so nothing is overwritten.
    always_comb begin
        valid_d = valid_q;
        ch_d    = ch_q;
        level_d = level_q;
        if (load_i) begin
            valid_d = 1'b1;
            ch_d    = ch_i;
            level_d = level_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ch_o    = ch_q;
    assign level_o = level_q;
    assign stall_o = valid_q & ~ready_i;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debounce of N_CH slow inputs with one shared compare/count engine.
// Latency: a stable change commits after at most (thresh+1)*N_CH cycles plus stall cycles.
// Backpressure: a pending, unaccepted event freezes counters, levels and the scan pointer.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEFAULT,
    parameter  int CNT_W = CNT_W_DEFAULT,
    localparam int IDX_W = idx_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  in_i,
    input  logic             cfg_en_i,
    input  logic [CNT_W-1:0] cfg_thresh_i,
    output logic [N_CH-1:0]  out_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDX_W-1:0] evt_ch_o,
    output logic             evt_level_o,
    output logic [IDX_W-1:0] scan_idx_o
);

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  out_q, out_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;

    logic             stall;
    logic             commit;
    logic             vis_in;
    logic             vis_out;
    logic [CNT_W-1:0] vis_cnt;

    // The channel under the scan pointer is the only one the engine touches.
    assign vis_in  = in_i[scan_idx_q];
    assign vis_out = out_q[scan_idx_q];
    assign vis_cnt = cnt_q[scan_idx_q];

    // Per-channel state, debounced levels and the scan pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q      <= '0;
            scan_idx_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q      <= out_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // Visit one channel per cycle: discard glitches, count mismatches, commit
    // at threshold. ">=" lets a lowered threshold commit on the next visit and
    // keeps the counter from ever wrapping.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        out_d      = out_q;
        scan_idx_d = scan_idx_q;
        commit     = 1'b0;
        if (!stall) begin
            if (!cfg_en_i) begin
                scan_idx_d = '0;
                for (int i = 0; i < N_CH; i++) begin
                    cnt_d[i] = '0;
                end
            end else begin
                if (vis_in == vis_out) begin
                    cnt_d[scan_idx_q] = '0;
                end else if (vis_cnt < cfg_thresh_i) begin
                    cnt_d[scan_idx_q] = vis_cnt + CNT_W'(1);
                end else begin
                    out_d[scan_idx_q] = vis_in;
                    cnt_d[scan_idx_q] = '0;
                    commit            = 1'b1;
                end
                scan_idx_d = IDX_W'(next_idx(int'(scan_idx_q), N_CH));
            end
        end
    end

    debounce_evt_slot #(
        .IDX_W (IDX_W)
    ) u_evt_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (commit),
        .ch_i    (scan_idx_q),
        .level_i (vis_in),
        .ready_i (evt_ready_i),
        .valid_o (evt_valid_o),
        .ch_o    (evt_ch_o),
        .level_o (evt_level_o),
        .stall_o (stall)
    );

    assign out_o      = out_q;
    assign scan_idx_o = scan_idx_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Randomized bench for debounce_scan_ctrl with a behavioural model and event scoreboard.
// Latency: n/a (testbench).
// Backpressure: evt_ready randomized per phase, including long back-pressure stretches.
module tb_debounce_scan_ctrl;

    localparam int N = 4;
    localparam int W = 4;

    typedef struct {
        int ch;
        int lvl;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_r = '0;
    logic         cfg_en = 1'b0;
    logic [W-1:0] cfg_thresh = '0;
    logic         evt_ready = 1'b0;
    logic [N-1:0] out_w;
    logic         evt_valid;
    logic [1:0]   evt_ch;
    logic         evt_level;
    logic [1:0]   scan_idx;

    int compared = 0;
    int mismatched = 0;

    // Reference model state, expressed as plain integers.
    logic [N-1:0] m_out;
    int           m_cnt [N];
    int           m_idx;
    bit           m_pend;
    ev_t          exp_q[$];

    // Randomization knobs (percent).
    int p_tog, p_en, p_rdy, p_th;

    debounce_scan_ctrl #(
        .N_CH  (N),
        .CNT_W (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_i         (in_r),
        .cfg_en_i     (cfg_en),
        .cfg_thresh_i (cfg_thresh),
        .out_o        (out_w),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (evt_ready),
        .evt_ch_o     (evt_ch),
        .evt_level_o  (evt_level),
        .scan_idx_o   (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_idx  = 0;
        m_pend = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        exp_q.delete();
    endtask

    // Apply one clock of the debounce rules to the model using the driven inputs.
    task automatic step_model();
        bit  stall, accept, commit;
        int  ch;
        ev_t e;
        stall  = m_pend && !evt_ready;
        accept = m_pend && evt_ready;
        commit = 1'b0;
        if (!stall) begin
            if (!cfg_en) begin
                m_idx = 0;
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else begin
                ch = m_idx;
                if (in_r[ch] == m_out[ch]) begin
                    m_cnt[ch] = 0;
                end else if (m_cnt[ch] < int'(cfg_thresh)) begin
                    m_cnt[ch] = m_cnt[ch] + 1;
                end else begin
                    m_out[ch] = in_r[ch];
                    m_cnt[ch] = 0;
                    commit    = 1'b1;
                    e.ch      = ch;
                    e.lvl     = int'(in_r[ch]);
                    exp_q.push_back(e);
                end
                m_idx = (m_idx + 1) % N;
            end
        end
        if (commit) m_pend = 1'b1;
        else if (accept) m_pend = 1'b0;
    endtask

    task automatic randomize_inputs();
        for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 99) < p_tog) in_r[c] = ~in_r[c];
        end
        cfg_en    = ($urandom_range(0, 99) < p_en);
        evt_ready = ($urandom_range(0, 99) < p_rdy);
        if ($urandom_range(0, 99) < p_th) cfg_thresh = W'($urandom_range(0, 5));
    endtask

    // One cycle: check state after the last edge, then drive and predict the next.
    task automatic cycle(input bit rnd);
        @(negedge clk);
        chk("out", int'(out_w), int'(m_out));
        chk("scan_idx", int'(scan_idx), m_idx);
        chk("evt_valid", int'(evt_valid), int'(m_pend));
        if (rnd) randomize_inputs();
        step_model();
    endtask

    // Monitor: every handshake must match the oldest expected event.
    always begin
        ev_t e;
        @(negedge clk);
        #2;
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", int'(evt_ch), -1);
            end else begin
                e = exp_q.pop_front();
                chk("evt_ch", int'(evt_ch), e.ch);
                chk("evt_level", int'(evt_level), e.lvl);
            end
        end
    end

    initial begin
        model_reset();
        #3;
        chk("rst_out", int'(out_w), 0);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_ch", int'(evt_ch), 0);
        chk("rst_evt_level", int'(evt_level), 0);
        chk("rst_scan_idx", int'(scan_idx), 0);

        // Release reset on a falling edge with scanning enabled.
        @(negedge clk);
        rst_n      = 1'b1;
        cfg_en     = 1'b1;
        cfg_thresh = 4'd2;
        evt_ready  = 1'b1;
        step_model();

        // Fixed threshold, always ready: basic filtering and glitch rejection.
        p_tog = 4; p_en = 100; p_rdy = 100; p_th = 0;
        repeat (300) cycle(1'b1);

        // Moving threshold, intermittent readiness and enable drops.
        p_tog = 5; p_en = 95; p_rdy = 50; p_th = 3;
        repeat (400) cycle(1'b1);

        // Heavy back-pressure.
        p_tog = 6; p_en = 98; p_rdy = 15; p_th = 2;
        repeat (300) cycle(1'b1);

        // Asynchronous reset in the middle of activity.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out", int'(out_w), 0);
        chk("arst_evt_valid", int'(evt_valid), 0);
        chk("arst_evt_ch", int'(evt_ch), 0);
        chk("arst_evt_level", int'(evt_level), 0);
        chk("arst_scan_idx", int'(scan_idx), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        in_r       = 4'b1111;
        cfg_en     = 1'b1;
        cfg_thresh = 4'd1;
        evt_ready  = 1'b1;
        rst_n      = 1'b1;
        step_model();
        repeat (30) cycle(1'b0);
        chk("rst_exit_out", int'(out_w), 15);

        // Everything random.
        p_tog = 5; p_en = 90; p_rdy = 60; p_th = 5;
        repeat (400) cycle(1'b1);

        // Drain: inputs frozen, consumer always ready.
        evt_ready = 1'b1;
        cfg_en    = 1'b1;
        repeat (80) cycle(1'b0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
